uart_tx_scheduler: RTL and testbench

//  Shares one UART transmitter among N_REQ requesters; round-robin arbitration, one byte per grant.

---
 rtl/uart_tx_scheduler.sv | 150 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter among N_REQ byte sources.
// Build option UART_TX_SCHED_PRIO_EN: requester 0 becomes fixed highest priority.
module uart_tx_scheduler #(
  parameter int N_REQ         = 4,
  parameter int START_TIMEOUT = 1024,
  parameter int PTR_W         = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [5*N_REQ-1:0] req_lcr,
  input  logic [2*N_REQ-1:0] req_baud,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   err,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic [4:0]         tx_lcr,
  output logic [1:0]         tx_baud_sel,
  output logic               tx_start,
  input  logic               tx_active,
  input  logic               tx_done,
  output logic               busy
);
  localparam int               TMR_W    = $clog2(START_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_START   = 3'd2,
    S_BUSY    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t           state_r;
  logic [PTR_W-1:0] rr_ptr_r;
  logic [PTR_W-1:0] winner_r;
  logic [TMR_W-1:0] timer_r;
  logic             tx_done_q_r;
  logic [PTR_W-1:0] pick_s;
  logic [PTR_W-1:0] scan_s;
  logic             pick_valid_s;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
    if (idx == PTR_W'(N_REQ - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return idx + PTR_W'(1);
    end
  endfunction

  // Winner search: first requester at or above rr_ptr_r, wrapping; requester 0 pre-empts in priority builds.
  always_comb begin
    pick_s = {PTR_W{1'b0}};
    scan_s = rr_ptr_r;
`ifdef UART_TX_SCHED_PRIO_EN
    pick_valid_s = req[0];
`else
    pick_valid_s = 1'b0;
`endif
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_valid_s && req[scan_s]) begin
        pick_s       = scan_s;
        pick_valid_s = 1'b1;
      end else begin
        scan_s = next_idx(scan_s);
      end
    end
  end

  // Frame sequencer: arbitration, transmitter handshake, start timeout and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      rr_ptr_r    <= {PTR_W{1'b0}};
      winner_r    <= {PTR_W{1'b0}};
      timer_r     <= {TMR_W{1'b0}};
      tx_done_q_r <= 1'b0;
      ack         <= {N_REQ{1'b0}};
      err         <= {N_REQ{1'b0}};
      grant       <= {N_REQ{1'b0}};
      tx_data     <= 8'h00;
      tx_lcr      <= 5'h00;
      tx_baud_sel <= 2'b00;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      tx_done_q_r <= tx_done;
      tx_start    <= 1'b0;
      ack         <= {N_REQ{1'b0}};
      err         <= {N_REQ{1'b0}};
      case (state_r)
        S_IDLE: begin
          if (pick_valid_s) begin
            winner_r <= pick_s;
            grant    <= ONE_HOT0 << pick_s;
            busy     <= 1'b1;
            state_r  <= S_GRANT;
          end
        end
        S_GRANT: begin
          tx_data     <= req_data[8*winner_r +: 8];
          tx_lcr      <= req_lcr[5*winner_r +: 5];
          tx_baud_sel <= req_baud[2*winner_r +: 2];
          tx_start    <= 1'b1;
          timer_r     <= {TMR_W{1'b0}};
          state_r     <= S_START;
        end
        S_START: begin
          if (tx_active) begin
            state_r <= S_BUSY;
          end else if (timer_r == TMR_LAST) begin
            ack     <= grant;
            err     <= grant;
            state_r <= S_RELEASE;
          end else if (timer_r != TMR_MAX) begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        S_BUSY: begin
          // tx_done_q_r already tracks tx_done during START, so a level held high on entry is not an edge.
          if (tx_done && !tx_done_q_r) begin
            ack     <= grant;
            state_r <= S_RELEASE;
          end
        end
        S_RELEASE: begin
`ifdef UART_TX_SCHED_PRIO_EN
          if (winner_r != {PTR_W{1'b0}}) begin
            rr_ptr_r <= next_idx(winner_r);
          end
`else
          rr_ptr_r <= next_idx(winner_r);
`endif
          grant   <= {N_REQ{1'b0}};
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          grant   <= {N_REQ{1'b0}};
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed vector table, reset/drop sequences, and random frames
// checked against a transaction-level round-robin model.
module tb_uart_tx_scheduler;
  logic        clk, rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [19:0] req_lcr;
  logic [7:0]  req_baud;
  logic [3:0]  ack, err, grant;
  logic [7:0]  tx_data;
  logic [4:0]  tx_lcr;
  logic [1:0]  tx_baud_sel;
  logic        tx_start, tx_active, tx_done, busy;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [19:0] lcr;
    logic [7:0]  baud;
    int          d;
    int          l;
    bit          to;
    bit          drop;
    int          exp_w;
    logic [7:0]  exp_data;
    logic [4:0]  exp_lcr;
    logic [1:0]  exp_baud;
  } vec_t;

  vec_t tbl[14];

  uart_tx_scheduler #(.N_REQ(4), .START_TIMEOUT(16), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_lcr(req_lcr),
    .req_baud(req_baud), .ack(ack), .err(err), .grant(grant), .tx_data(tx_data),
    .tx_lcr(tx_lcr), .tx_baud_sel(tx_baud_sel), .tx_start(tx_start),
    .tx_active(tx_active), .tx_done(tx_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic [3:0] r, logic [31:0] dt, logic [19:0] lc, logic [7:0] bd,
                              int d, int l, bit to, bit dr, int w,
                              logic [7:0] ed, logic [4:0] el, logic [1:0] eb);
    vec_t v;
    v.req = r; v.data = dt; v.lcr = lc; v.baud = bd; v.d = d; v.l = l; v.to = to; v.drop = dr;
    v.exp_w = w; v.exp_data = ed; v.exp_lcr = el; v.exp_baud = eb;
    return v;
  endfunction

  // Round-robin reference: first pending requester at or after the pointer, wrapping.
  function automatic int model_pick(logic [3:0] r, int ptr);
    for (int k = 0; k < 4; k++) begin
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return 0;
  endfunction

  // One frame from an IDLE cycle: drives the fake transmitter and checks every cycle until back in IDLE.
  task automatic run_frame(input vec_t v, input bit pre);
    logic [3:0] wv;
    int c_done, n_ack;
    wv = 4'b0001 << v.exp_w;
    req = v.req; req_data = v.data; req_lcr = v.lcr; req_baud = v.baud;
    tick();
    chk("grant_cycle", 64'({ack, grant, tx_start, busy}), 64'({4'b0000, wv, 1'b0, 1'b1}));
    tick();
    chk("tx_start", 64'({tx_start, grant}), 64'({1'b1, wv}));
    chk("tx_bus", 64'({tx_data, tx_lcr, tx_baud_sel}), 64'({v.exp_data, v.exp_lcr, v.exp_baud}));
    req_data = $urandom; req_lcr = 20'($urandom); req_baud = 8'($urandom);
    c_done = pre ? v.d + 2 + v.l : v.d + 1 + v.l;
    n_ack  = v.to ? 16 : c_done + 1;
    for (int c = 0; c <= n_ack; c++) begin
      if (c > 0) begin
        tick();
        if (c < n_ack) begin
          chk("mid_ctl", 64'({ack, err, tx_start, busy, grant}), 64'({8'h00, 1'b0, 1'b1, wv}));
          chk("mid_bus", 64'({tx_data, tx_lcr, tx_baud_sel}), 64'({v.exp_data, v.exp_lcr, v.exp_baud}));
        end else begin
          chk("ack", 64'(ack), 64'(wv));
          chk("err", 64'(err), 64'(v.to ? wv : 4'b0000));
          chk("rel_ctl", 64'({busy, grant, tx_start}), 64'({1'b1, wv, 1'b0}));
        end
      end
      if (!v.to && c == v.d) begin
        tx_active = 1'b1;
        tx_done   = pre;
      end
      if (!v.to && pre && c == v.d + 1) tx_done = 1'b0;
      if (!v.to && c == c_done) tx_done = 1'b1;
      if (v.drop && c == v.d + 1) req[v.exp_w] = 1'b0;
    end
    tick();
    chk("idle_ctl", 64'({ack, err, grant, busy, tx_start}), 64'd0);
    chk("idle_bus", 64'({tx_data, tx_lcr, tx_baud_sel}), 64'({v.exp_data, v.exp_lcr, v.exp_baud}));
    tx_active = 1'b0;
    tx_done   = 1'b0;
    m_ptr = (v.exp_w + 1) % 4;
  endtask

  initial begin
    vec_t       rv;
    logic [3:0] mask;
    int         w;
    bit         pre;
    logic [31:0] dd = 32'h44332211;
    logic [19:0] ll = 20'h41041;
    logic [7:0]  bb = 8'hE4;

    tbl[0]  = mk(4'b1111, dd, ll, bb, 0, 2, 1'b0, 1'b0, 0, 8'h11, 5'h01, 2'd0);
    tbl[1]  = mk(4'b1111, dd, ll, bb, 1, 0, 1'b0, 1'b0, 1, 8'h22, 5'h02, 2'd1);
    tbl[2]  = mk(4'b1111, dd, ll, bb, 2, 3, 1'b0, 1'b0, 2, 8'h33, 5'h04, 2'd2);
    tbl[3]  = mk(4'b1111, dd, ll, bb, 0, 1, 1'b0, 1'b0, 3, 8'h44, 5'h08, 2'd3);
    tbl[4]  = mk(4'b1111, dd, ll, bb, 3, 0, 1'b0, 1'b0, 0, 8'h11, 5'h01, 2'd0);
    tbl[5]  = mk(4'b0100, 32'h00A50000, 20'h00C00, 8'h10, 1, 4, 1'b0, 1'b0, 2, 8'hA5, 5'h03, 2'd1);
    tbl[6]  = mk(4'b0011, dd, ll, bb, 0, 0, 1'b0, 1'b0, 0, 8'h11, 5'h01, 2'd0);
    tbl[7]  = mk(4'b0011, dd, ll, bb, 1, 1, 1'b0, 1'b0, 1, 8'h22, 5'h02, 2'd1);
    tbl[8]  = mk(4'b1001, dd, ll, bb, 0, 2, 1'b0, 1'b0, 3, 8'h44, 5'h08, 2'd3);
    tbl[9]  = mk(4'b1000, dd, ll, bb, 2, 0, 1'b0, 1'b0, 3, 8'h44, 5'h08, 2'd3);
    tbl[10] = mk(4'b0110, dd, ll, bb, 0, 0, 1'b0, 1'b0, 1, 8'h22, 5'h02, 2'd1);
    tbl[11] = mk(4'b0110, dd, ll, bb, 1, 1, 1'b0, 1'b0, 2, 8'h33, 5'h04, 2'd2);
    tbl[12] = mk(4'b0001, dd, ll, bb, 0, 0, 1'b1, 1'b0, 0, 8'h11, 5'h01, 2'd0);
    tbl[13] = mk(4'b1000, dd, ll, bb, 1, 2, 1'b0, 1'b1, 3, 8'h44, 5'h08, 2'd3);

    rst = 1'b0; req = 4'b0000; req_data = 32'h0; req_lcr = 20'h0; req_baud = 8'h0;
    tx_active = 1'b0; tx_done = 1'b0;
    #12;
    chk("reset_state", 64'({ack, err, grant, tx_start, busy, tx_data, tx_lcr, tx_baud_sel}), 64'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) run_frame(tbl[i], 1'b0);

    // Requester 3 dropped its request mid-frame: nothing left to serve.
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_regrant", 64'({busy, grant}), 64'd0);
    end

    req = 4'b0100; req_data = dd; req_lcr = ll; req_baud = bb;
    tick();
    tick();
    tx_active = 1'b1;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("async_reset", 64'({ack, err, grant, tx_start, busy, tx_data, tx_lcr, tx_baud_sel}), 64'd0);
    tx_active = 1'b0;
    req = 4'b0000;
    tick();
    #3 rst = 1'b1;
    tick();
    m_ptr = 0;
    run_frame(mk(4'b0110, dd, ll, bb, 1, 1, 1'b0, 1'b0, 1, 8'h22, 5'h02, 2'd1), 1'b0);

    for (int n = 0; n < 60; n++) begin
      mask = req | (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) mask = mask & ~(4'b0001 << ((m_ptr + 3) % 4));
      if (mask == 4'b0000) mask = 4'($urandom_range(1, 15));
      rv.req = mask; rv.data = $urandom; rv.lcr = 20'($urandom); rv.baud = 8'($urandom);
      rv.d = $urandom_range(0, 3); rv.l = $urandom_range(0, 4);
      rv.to = ($urandom_range(0, 7) == 0); rv.drop = ($urandom_range(0, 5) == 0);
      w = model_pick(mask, m_ptr);
      rv.exp_w = w;
      rv.exp_data = rv.data[8*w +: 8];
      rv.exp_lcr  = rv.lcr[5*w +: 5];
      rv.exp_baud = rv.baud[2*w +: 2];
      pre = !rv.to && ($urandom_range(0, 3) == 0);
      run_frame(rv, pre);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
